// File: rtl/double_exp_sched.sv
// Round-robin scheduler that shares one double_exp unit among REQS requesters.
// It sequences the unit's ld/setup/operand protocol and routes the result back to the granted requester.
module double_exp_sched #(
  parameter int REQS         = 4,
  parameter int WIDTH        = 8,
  parameter int LD_CYCLES    = 8,
  parameter int SETUP_CYCLES = 6,
  parameter int TIMEOUT      = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQS-1:0]       req_valid,
  output logic [REQS-1:0]       req_ready,
  input  logic [REQS*WIDTH-1:0] req_xs,
  input  logic [REQS*WIDTH-1:0] req_xc,
  output logic [REQS-1:0]       rsp_valid,
  input  logic [REQS-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_ys,
  output logic [WIDTH-1:0]      rsp_yc,
  output logic                  rsp_err,
  output logic                  de_ld,
  output logic [WIDTH-1:0]      de_xs,
  output logic [WIDTH-1:0]      de_xc,
  input  logic                  de_dn,
  input  logic [WIDTH-1:0]      de_ys,
  input  logic [WIDTH-1:0]      de_yc
);

  localparam int IW   = $clog2(REQS);
  localparam int CMAX = (LD_CYCLES > SETUP_CYCLES) ? LD_CYCLES : SETUP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, FEED, BUSY, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   pick;
  logic            pick_ok;
  logic [CW-1:0]   cnt;
  logic [11:0]     tcnt;
  logic [WIDTH-1:0] op_xs;
  logic [WIDTH-1:0] op_xc;
  logic            dn_q;
  logic            dn_rise;

  // Only a rising edge of dn completes a job; a level left high from before does not.
  assign dn_rise = de_dn & ~dn_q;

  // Scan from the pointer downwards in priority so the requester closest to ptr wins last.
  always_comb begin
    // NOTE: defaults first so every path assigns pick/pick_ok; otherwise latches are inferred.
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = REQS - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= REQS) j = j - REQS;
      if (req_valid[IW'(j)]) begin
        pick    = IW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      op_xs     <= '0;
      op_xc     <= '0;
      dn_q      <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_ys    <= '0;
      rsp_yc    <= '0;
      rsp_err   <= 1'b0;
      de_ld     <= 1'b0;
      de_xs     <= '0;
      de_xc     <= '0;
    end else begin
      // NOTE: nonblocking assignments so every register here samples pre-edge values.
      dn_q      <= de_dn;
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            gnt       <= pick;
            req_ready <= REQS'(1) << pick;
            op_xs     <= req_xs[int'(pick)*WIDTH +: WIDTH];
            op_xc     <= req_xc[int'(pick)*WIDTH +: WIDTH];
            de_ld     <= 1'b1;
            cnt       <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (cnt == CW'(LD_CYCLES - 1)) begin
            cnt   <= '0;
            de_ld <= 1'b0;
            state <= SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            cnt   <= '0;
            de_xs <= op_xs;
            de_xc <= op_xc;
            state <= FEED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FEED: begin
          de_xs <= '0;
          de_xc <= '0;
          tcnt  <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (dn_rise) begin
            rsp_ys    <= de_ys;
            rsp_yc    <= de_yc;
            rsp_err   <= 1'b0;
            rsp_valid <= REQS'(1) << gnt;
            state     <= RESP;
          end else if (tcnt == 12'(TIMEOUT - 1)) begin
            rsp_ys    <= '0;
            rsp_yc    <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= REQS'(1) << gnt;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            ptr       <= (int'(gnt) == REQS - 1) ? '0 : gnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_double_exp_sched.sv
// Self-checking bench for double_exp_sched: directed scenarios plus randomized jobs
// compared against a round-robin/timing reference model.
`timescale 1ns/1ps
module tb_double_exp_sched;

  localparam int REQS    = 4;
  localparam int WIDTH   = 8;
  localparam int LD      = 8;
  localparam int SETUP   = 6;
  localparam int TIMEOUT = 4095;
  localparam int IW      = $clog2(REQS);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [REQS-1:0]       req_valid;
  logic [REQS-1:0]       req_ready;
  logic [REQS*WIDTH-1:0] req_xs;
  logic [REQS*WIDTH-1:0] req_xc;
  logic [REQS-1:0]       rsp_valid;
  logic [REQS-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_ys;
  logic [WIDTH-1:0]      rsp_yc;
  logic                  rsp_err;
  logic                  de_ld;
  logic [WIDTH-1:0]      de_xs;
  logic [WIDTH-1:0]      de_xc;
  logic                  de_dn;
  logic [WIDTH-1:0]      de_ys;
  logic [WIDTH-1:0]      de_yc;

  int vectors    = 0;
  int miscompares = 0;
  int mptr       = 0;

  double_exp_sched #(
    .REQS(REQS), .WIDTH(WIDTH), .LD_CYCLES(LD), .SETUP_CYCLES(SETUP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_xs(req_xs), .req_xc(req_xc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ys(rsp_ys), .rsp_yc(rsp_yc),
    .rsp_err(rsp_err), .de_ld(de_ld), .de_xs(de_xs), .de_xc(de_xc),
    .de_dn(de_dn), .de_ys(de_ys), .de_yc(de_yc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference arbiter: first valid requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [REQS-1:0] v, input int p);
    for (int i = 0; i < REQS; i++) begin
      int k;
      k = (p + i) % REQS;
      if (v[IW'(k)]) return k;
    end
    return -1;
  endfunction

  // One complete job. d>0: dn rises in BUSY cycle d; d==0: unit never answers (timeout).
  // pre: spurious dn pulse in LOAD, dn high from SETUP into BUSY, falling in BUSY cycle 3.
  task automatic do_job(input logic [REQS-1:0] vmask, input int d, input int bp, input bit pre,
                        input bit fixed, input logic [4*WIDTH-1:0] fv, output int gobs);
    int g, lat;
    logic [WIDTH-1:0] xs, xc, ys, yc;
    logic [LD+SETUP:0] ldv;
    logic [2*WIDTH-1:0] post_x;
    logic [2*WIDTH+REQS:0] snap;
    bit rdy_bad, unstable;
    logic [REQS-1:0] acc;

    g = rr_pick(vmask, mptr);
    for (int i = 0; i < REQS; i++) begin
      req_xs[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_xc[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    ys = WIDTH'($urandom);
    yc = WIDTH'($urandom);
    if (fixed) begin
      req_xs[g*WIDTH +: WIDTH] = fv[4*WIDTH-1 -: WIDTH];
      req_xc[g*WIDTH +: WIDTH] = fv[3*WIDTH-1 -: WIDTH];
      ys = fv[2*WIDTH-1 -: WIDTH];
      yc = fv[WIDTH-1:0];
    end
    xs = req_xs[g*WIDTH +: WIDTH];
    xc = req_xc[g*WIDTH +: WIDTH];
    req_valid = vmask;

    lat = 0;
    while (req_ready == '0 && lat < 50) begin
      step();
      lat++;
    end
    check("grant_lat", lat, 1);
    check("grant", req_ready, 32'(1) << g);
    gobs = -1;
    for (int i = 0; i < REQS; i++) if (req_ready[IW'(i)]) gobs = i;
    req_valid = REQS'($urandom);

    rdy_bad = 1'b0;
    ldv = '0;
    for (int k = 0; k <= LD + SETUP; k++) begin
      ldv = {de_ld, ldv[LD+SETUP:1]};
      if (k > 0 && req_ready != '0) rdy_bad = 1'b1;
      if (k < LD + SETUP && (de_xs != '0 || de_xc != '0)) rdy_bad = 1'b1;
      if (pre && k == 2) de_dn = 1'b1;
      if (pre && k == 3) de_dn = 1'b0;
      if (pre && k == LD + 2) de_dn = 1'b1;
      if (k < LD + SETUP) step();
    end
    check("ld_seq", 32'(ldv), (32'(1) << LD) - 1);
    check("quiet_load", 32'(rdy_bad), 0);
    check("feed_xs", de_xs, xs);
    check("feed_xc", de_xc, xc);

    de_ys = ys;
    de_yc = yc;
    post_x = '1;
    lat = 0;
    while (lat < TIMEOUT + 50) begin
      step();
      lat++;
      if (rsp_valid != '0) break;
      if (lat == 1) post_x = {de_xs, de_xc};
      if (pre && lat == 3) de_dn = 1'b0;
      if (d > 0 && lat == d) de_dn = 1'b1;
    end
    check("feed_clear", post_x, 0);
    check("rsp_lat", lat, (d > 0) ? d + 1 : TIMEOUT + 1);
    check("rsp_valid", rsp_valid, 32'(1) << g);
    check("rsp_ys", rsp_ys, (d > 0) ? ys : 0);
    check("rsp_yc", rsp_yc, (d > 0) ? yc : 0);
    check("rsp_err", rsp_err, (d > 0) ? 0 : 1);
    de_dn = 1'b0;

    snap = {rsp_valid, rsp_ys, rsp_yc, rsp_err};
    unstable = 1'b0;
    for (int k = 0; k < bp; k++) begin
      acc = REQS'($urandom);
      acc[IW'(g)] = 1'b0;
      rsp_ready = acc;
      de_dn = k[0];
      step();
      if ({rsp_valid, rsp_ys, rsp_yc, rsp_err} != snap || req_ready != '0 || de_ld) unstable = 1'b1;
    end
    check("hold", 32'(unstable), 0);
    de_dn = 1'b0;
    acc = REQS'($urandom);
    acc[IW'(g)] = 1'b1;
    rsp_ready = acc;
    step();
    check("rsp_clear", {rsp_valid, rsp_err}, 0);
    mptr = (g + 1) % REQS;
    rsp_ready = '0;
    req_valid = '0;
  endtask

  initial begin
    int gobs, lat;
    int order[5];
    bit bad;
    logic [REQS-1:0] vm;
    int d, bp;
    bit pre;

    rst_n = 1'b0;
    req_valid = '0; req_xs = '0; req_xc = '0; rsp_ready = '0;
    de_dn = 1'b0; de_ys = '0; de_yc = '0;
    step(); step();
    check("reset_ctl", {req_ready, rsp_valid, rsp_err, de_ld}, 0);
    check("reset_dat", {de_xs, de_xc, rsp_ys, rsp_yc}, 0);
    rst_n = 1'b1;

    // No grant while nothing is requested.
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (req_ready != '0 || de_ld) bad = 1'b1;
    end
    check("idle_no_grant", 32'(bad), 0);

    // Round robin with everyone requesting.
    for (int j = 0; j < 5; j++) begin
      do_job('1, 1 + j, 0, 1'b0, 1'b0, '0, gobs);
      order[j] = gobs;
    end
    check("rr_order", {8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}, 32'h00010203);
    check("rr_wrap", order[4], 0);

    // Single job with known operands and result.
    do_job(4'b0001, 4, 0, 1'b0, 1'b1, {8'd37, 8'd5, 8'd12, 8'd3}, gobs);
    check("single_gnt", gobs, 0);

    // Backpressure for 20 cycles.
    do_job(4'b0110, 7, 20, 1'b0, 1'b0, '0, gobs);

    // Timeout, then a normal job.
    do_job(4'b1000, 0, 2, 1'b0, 1'b0, '0, gobs);
    do_job(4'b1000, 3, 0, 1'b0, 1'b0, '0, gobs);

    // dn already high entering BUSY; completion only on the later rise.
    do_job(4'b0010, 33, 1, 1'b1, 1'b0, '0, gobs);

    // Randomized jobs.
    for (int n = 0; n < 30; n++) begin
      vm  = REQS'($urandom_range(1, (1 << REQS) - 1));
      pre = ($urandom_range(0, 4) == 0);
      d   = pre ? int'($urandom_range(5, 40)) : int'($urandom_range(1, 25));
      bp  = $urandom_range(0, 4);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
      do_job(vm, d, bp, pre, 1'b0, '0, gobs);
    end

    // Reset during SETUP: set pointer to 2 first, abort a job from requester 2.
    do_job(4'b0010, 2, 0, 1'b0, 1'b0, '0, gobs);
    req_valid = 4'b0100;
    lat = 0;
    while (req_ready == '0 && lat < 50) begin
      step();
      lat++;
    end
    check("abort_gnt", req_ready, 4'b0100);
    req_valid = '0;
    for (int k = 0; k < LD + 2; k++) step();
    rst_n = 1'b0;
    #1;
    check("rst_abort", {de_ld, req_ready, rsp_valid, rsp_err, de_xs}, 0);
    mptr = 0;
    step();
    rst_n = 1'b1;
    do_job(4'b0101, 5, 0, 1'b0, 1'b0, '0, gobs);
    check("post_rst_gnt", gobs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
